// File: rtl/iter_alu_pkg.sv
// ----------------------------------------------------------------------------
// iter_alu_pkg
//   Shared types and constants for the iterative ALU.
//   - op_e     : opcode map (0 gnd, 1 add, 2 sub, 3 mul, 4 div, 5 mod)
//   - state_e  : control FSM states
//   - ERR_*    : bit indices into the 2-bit error word
//   - uses_divider() : opcodes that are routed through the restoring divider
// Build option: ITER_ALU_MOD_EN -- when defined, opcode 5 returns the
//   divider remainder; otherwise opcode 5 behaves like gnd.
// ----------------------------------------------------------------------------
package iter_alu_pkg;

    typedef enum logic [3:0] {
        OP_GND = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_MUL = 4'd3,
        OP_DIV = 4'd4,
        OP_MOD = 4'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int ERR_DIV0  = 1;
    localparam int ERR_CARRY = 0;

    function automatic logic uses_divider(input logic [3:0] op);
`ifdef ITER_ALU_MOD_EN
        return (op == OP_DIV) || (op == OP_MOD);
`else
        return (op == OP_DIV);
`endif
    endfunction

endpackage

// File: rtl/iter_alu_if.sv
// ----------------------------------------------------------------------------
// iter_alu_if
//   Operand-side and result-side valid/ready handshakes of the iterative ALU.
//   master : operand source / result sink (drives in_valid, operands, out_ready)
//   slave  : the ALU (drives in_ready, out_valid, result, error)
//   Signals: in_valid, in_ready, op_a[WIDTH], op_b[WIDTH], opcode[4],
//            out_valid, out_ready, result[2*WIDTH], error[2]
// ----------------------------------------------------------------------------
interface iter_alu_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [3:0]           opcode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic [1:0]           error;

    modport master (
        output in_valid, op_a, op_b, opcode, out_ready,
        input  in_ready, out_valid, result, error
    );

    modport slave (
        input  in_valid, op_a, op_b, opcode, out_ready,
        output in_ready, out_valid, result, error
    );
endinterface

// File: rtl/iter_alu_divider.sv
// ----------------------------------------------------------------------------
// iter_alu_divider
//   WIDTH-step restoring divider. A one-cycle i_start loads the operands; one
//   quotient bit is resolved per cycle, and o_done pulses for one cycle in the
//   cycle after the last step, with o_quotient valid from then on.
//   Ports: clk, rst (async, active-high), i_start, i_dividend[WIDTH],
//          i_divisor[WIDTH] (must be non-zero), o_done, o_quotient[WIDTH],
//          o_remainder[WIDTH] (only when ITER_ALU_MOD_EN is defined)
// ----------------------------------------------------------------------------
module iter_alu_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient
`ifdef ITER_ALU_MOD_EN
    ,
    output logic [WIDTH-1:0] o_remainder
`endif
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;

    // Partial remainder shifted left with the next dividend bit brought in;
    // the dividend register doubles as the quotient shift register.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_div};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_quo  <= i_dividend;
                r_div  <= i_divisor;
                r_rem  <= '0;
                r_cnt  <= CNT_W'(WIDTH);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                // Restore (keep shifted remainder) when the trial subtract borrows.
                if (!w_diff[WIDTH]) begin
                    r_rem <= w_diff[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                end else begin
                    r_rem <= w_rem_sh[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                end
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done     = r_done;
    assign o_quotient = r_quo;
`ifdef ITER_ALU_MOD_EN
    assign o_remainder = r_rem;
`endif

endmodule

// File: rtl/iter_alu.sv
// ----------------------------------------------------------------------------
// iter_alu
//   Sequential ALU: add/sub in one cycle, multiply as a WIDTH-step LSB-first
//   shift-add, divide/modulo through the restoring divider sub-module.
//   Operands are latched on in_valid&&in_ready (only in IDLE); the result is
//   held with out_valid until out_ready. Divide/mod by zero skips iteration.
//   Ports: clk, rst (async, active-high), bus (iter_alu_if.slave):
//          in_valid/in_ready, op_a, op_b, opcode, out_valid/out_ready,
//          result[2*WIDTH], error[2] ([1] div-by-zero, [0] carry/borrow)
// Build option: ITER_ALU_MOD_EN -- enables opcode 5 (remainder); when
//   undefined opcode 5 returns 0 with error 0 after one cycle.
// ----------------------------------------------------------------------------
module iter_alu
    import iter_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    iter_alu_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    state_e               r_state;
    state_e               w_state_next;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [3:0]           r_op;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_result;
    logic [1:0]           r_error;

    logic                 w_accept;
    logic                 w_div_start;
    logic                 w_div_done;
    logic [WIDTH-1:0]     w_quo;
    logic                 w_div_op;
    logic                 w_div0;
    logic                 w_exec_done;
    logic                 w_in_ready;
    logic                 w_out_valid;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_res;
    logic [1:0]           w_err;
`ifdef ITER_ALU_MOD_EN
    logic [WIDTH-1:0]     w_rem;
`endif

    assign w_accept = bus.in_valid && w_in_ready;

    // The divider is started from the live inputs on the accept edge so that
    // its WIDTH steps line up with the multiplier's WIDTH steps.
    assign w_div_start = w_accept && uses_divider(bus.opcode) && (bus.op_b != '0);

    iter_alu_divider #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (bus.op_a),
        .i_divisor  (bus.op_b),
        .o_done     (w_div_done),
        .o_quotient (w_quo)
`ifdef ITER_ALU_MOD_EN
        ,
        .o_remainder(w_rem)
`endif
    );

    assign w_div_op = uses_divider(r_op);
    assign w_div0   = w_div_op && (r_b == '0);
    assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff   = {1'b0, r_a} - {1'b0, r_b};

    // The multiplier finishes one cycle after its last step (counter at
    // WIDTH); the divider finishes on its done pulse; everything else at once.
    always_comb begin
        w_exec_done = 1'b1;
        if (r_op == OP_MUL) begin
            w_exec_done = (r_cnt == CNT_MAX);
        end else if (w_div_op && !w_div0) begin
            w_exec_done = w_div_done;
        end
    end

    always_comb begin
        w_res = '0;
        w_err = '0;
        case (r_op)
            OP_ADD: begin
                w_res            = {{(WIDTH-1){1'b0}}, w_sum};
                w_err[ERR_CARRY] = w_sum[WIDTH];
            end
            OP_SUB: begin
                // (WIDTH+1)-bit difference sign-extended to the full result.
                w_res            = {{(WIDTH-1){w_diff[WIDTH]}}, w_diff};
                w_err[ERR_CARRY] = w_diff[WIDTH];
            end
            OP_MUL: w_res = r_acc;
            OP_DIV: begin
                if (w_div0) w_err[ERR_DIV0] = 1'b1;
                else        w_res = {{WIDTH{1'b0}}, w_quo};
            end
`ifdef ITER_ALU_MOD_EN
            OP_MOD: begin
                if (w_div0) w_err[ERR_DIV0] = 1'b1;
                else        w_res = {{WIDTH{1'b0}}, w_rem};
            end
`endif
            default: ;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_next = EXEC;
            end
            EXEC: begin
                if (w_exec_done) w_state_next = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand latches, shift-add multiplier and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_result <= '0;
            r_error  <= '0;
        end else if (w_accept) begin
            r_a      <= bus.op_a;
            r_b      <= bus.op_b;
            r_op     <= bus.opcode;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, bus.op_a};
            r_mplier <= bus.op_b;
        end else if (r_state == EXEC) begin
            if ((r_op == OP_MUL) && (r_cnt != CNT_MAX)) begin
                if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
            end
            if (w_exec_done) begin
                r_result <= w_res;
                r_error  <= w_err;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.error     = r_error;

endmodule

// File: tb/tb_iter_alu.sv
// ----------------------------------------------------------------------------
// tb_iter_alu
//   Self-checking bench for iter_alu (WIDTH=16). A driver issues directed and
//   random operations and pushes the expected response (from a plain-arithmetic
//   model) into a queue; a monitor pops and compares on every transfer, and
//   also checks latency, hold-stability under backpressure and in_ready.
//   Honours ITER_ALU_MOD_EN the same way as the design.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_iter_alu;
    import iter_alu_pkg::*;

    localparam int W = 16;

    typedef struct {
        logic [3:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [31:0]   res;
        logic [1:0]    err;
        int            lat;
        int            acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   bp_mode = 0;   // 0 always ready, 1 held low, 2 random
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iter_alu_if #(.WIDTH(W)) bus();

    iter_alu #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Reference model: spec arithmetic on plain integers.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.op = op; e.a = a; e.b = b;
        e.res = '0; e.err = '0; e.lat = 1; e.acc = 0;
        case (op)
            4'd1: begin
                e.res    = 32'(a) + 32'(b);
                e.err[0] = (int'(a) + int'(b)) > 65535;
            end
            4'd2: begin
                e.res    = 32'(int'(a) - int'(b));
                e.err[0] = (a < b);
            end
            4'd3: begin
                e.res = 32'(a) * 32'(b);
                e.lat = W + 1;
            end
            4'd4: begin
                if (b == 0) e.err = 2'b10;
                else begin e.res = 32'(a / b); e.lat = W + 1; end
            end
`ifdef ITER_ALU_MOD_EN
            4'd5: begin
                if (b == 0) e.err = 2'b10;
                else begin e.res = 32'(a % b); e.lat = W + 1; end
            end
`endif
            default: ;
        endcase
        return e;
    endfunction

    // Sink backpressure generator.
    always begin
        @(posedge clk);
        #2;
        case (bp_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Monitor / scoreboard.
    initial begin : monitor
        bit            seen;
        logic [31:0]   hold_r;
        logic [1:0]    hold_e;
        exp_t          e;
        seen = 0; hold_r = '0; hold_e = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0;
                continue;
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out_valid: got result 0x%0h with nothing outstanding", bus.result);
                end else begin
                    e = exp_q[0];
                    if (!seen) begin
                        seen = 1;
                        chk("latency", 64'(cyc - e.acc - 1), 64'(e.lat));
                    end else begin
                        chk("hold_result", 64'(bus.result), 64'(hold_r));
                        chk("hold_error", 64'(bus.error), 64'(hold_e));
                    end
                    chk("in_ready_while_valid", 64'(bus.in_ready), 64'd0);
                    hold_r = bus.result;
                    hold_e = bus.error;
                    if (bus.out_ready) begin
                        chk("result", 64'(bus.result), 64'(e.res));
                        chk("error", 64'(bus.error), 64'(e.err));
                        $display("txn op=%0d a=0x%04h b=0x%04h result=0x%08h error=%b", e.op, e.a, e.b, bus.result, bus.error);
                        void'(exp_q.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    // Issue one operation; called and returns at posedge+#1.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   guard;
        guard = 0;
        while (!bus.in_ready) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 200) begin
                checks++; errors++;
                $display("FAIL in_ready_timeout: got in_ready=0 required 1 within 200 cycles");
                return;
            end
        end
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.opcode   = op;
        @(posedge clk);
        e     = model(op, a, b);
        e.acc = cyc;
        exp_q.push_back(e);
        #1;
        bus.in_valid = 1'b0;
        bus.op_a     = W'($urandom);
        bus.op_b     = W'($urandom);
        bus.opcode   = 4'($urandom);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0) || !bus.in_ready) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 500) begin
                checks++; errors++;
                $display("FAIL drain_timeout: got %0d outstanding required 0", exp_q.size());
                exp_q.delete();
                return;
            end
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    logic [3:0]   d_op [10] = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd5, 4'd4, 4'd5, 4'd9};
    logic [W-1:0] d_a  [10] = '{16'hFFFF, 16'h0001, 16'h0003, 16'hFFFF, 16'h0003, 16'd100, 16'd100, 16'd5, 16'd5, 16'hAAAA};
    logic [W-1:0] d_b  [10] = '{16'h0001, 16'h0003, 16'h0001, 16'hFFFF, 16'h0000, 16'd7, 16'd7, 16'd0, 16'd0, 16'h5555};

    initial begin : driver
        logic [3:0] rop;
        bus.in_valid = 1'b0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.opcode   = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_result", 64'(bus.result), 64'd0);
        chk("reset_error", 64'(bus.error), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a multiply aborts it.
        issue(4'd3, 16'h1234, 16'h5678);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        chk("abort_result", 64'(bus.result), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_output", 64'(bus.out_valid), 64'd0);
        issue(4'd1, 16'd3, 16'd1);
        drain();

        // Directed boundary cases.
        for (int i = 0; i < 10; i++) begin
            issue(d_op[i], d_a[i], d_b[i]);
            drain();
        end

        // Backpressure with in_valid pulses during EXEC/DONE.
        bp_mode = 1;
        issue(4'd3, 16'h1234, 16'h0010);
        for (int i = 0; i < W + 6; i++) begin
            @(posedge clk); #1;
            bus.in_valid = (i % 3 == 0);
            bus.opcode   = 4'd1;
            chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        chk("bp_out_valid_held", 64'(bus.out_valid), 64'd1);
        bp_mode = 0;
        drain();

        // Random traffic with random backpressure.
        bp_mode = 2;
        repeat (150) begin
            rop = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(6, 15));
            issue(rop, pick(), pick());
        end
        bp_mode = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
